// File: rtl/osd_spi_master.sv
// osd_spi_master: round-robin arbiter and SPI framer for the OSD overlay link.
// Each transaction is one command byte plus 0..256 payload bytes, sent MSB
// first on DI with SS3 held low. The enable state last sent to the overlay is
// mirrored on enable_state_o.
// Ports:
//   clk_sys, reset_n              system clock, async active-low reset
//   req_i[1:0]                    per-requester request (held until done_o)
//   cmd0_i/cmd1_i, len0_i/len1_i  command byte and payload length per requester
//   data0_i/data1_i               payload byte, valid one cycle after data_rd_o
//   data_rd_o, gnt_o, done_o      fetch strobe, one-hot grant, completion pulse
//   busy_o, enable_state_o        activity flag, enable mirror
//   spi_sck_o, spi_ss_o, spi_di_o SPI clock (idle low), select (active low), data
module osd_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic [7:0] cmd0_i,
  input  logic [7:0] cmd1_i,
  input  logic [8:0] len0_i,
  input  logic [8:0] len1_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  output logic [1:0] data_rd_o,
  output logic [1:0] gnt_o,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic       enable_state_o,
  output logic       spi_sck_o,
  output logic       spi_ss_o,
  output logic       spi_di_o
);

  localparam int unsigned CW = 9;
  localparam logic [CW-1:0] DIV_INIT  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LOAD_INIT = CW'(CLK_DIV + 1);
  localparam logic [CW-1:0] LOAD_CAP  = CW'(CLK_DIV);
  localparam logic [CW-1:0] GAP_INIT  = CW'(2 * CLK_DIV - 1);
  localparam logic [8:0]    MAX_LEN   = 9'd256;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_LOAD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [8:0]      byte_q, byte_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            gsel_q, gsel_d;
  logic            rr_q, rr_d;
  logic            sck_q, sck_d, ss_q, ss_d, di_q, di_d;
  logic            busy_q, busy_d, en_q, en_d;
  logic [1:0]      gnt_q, gnt_d, rd_q, rd_d, done_q, done_d;

  logic            div_zero_c, fall_c, pick_c;
  logic [7:0]      cmd_sel_c, data_sel_c;
  logic [8:0]      len_sel_c, len_clamp_c;

  // Arbitration: single request wins outright, contention goes to the requester not served last.
  always_comb begin
    pick_c      = (req_i == 2'b11) ? ~rr_q : req_i[1];
    cmd_sel_c   = pick_c ? cmd1_i : cmd0_i;
    len_sel_c   = pick_c ? len1_i : len0_i;
    len_clamp_c = (len_sel_c > MAX_LEN) ? MAX_LEN : len_sel_c;
    data_sel_c  = gsel_q ? data1_i : data0_i;
    div_zero_c  = (div_q == '0);
    fall_c      = (state_q == S_SHIFT) && div_zero_c && sck_q;
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_i) state_d = S_SETUP;
      S_SETUP: if (div_zero_c) state_d = S_SHIFT;
      S_SHIFT: if (fall_c && (bit_q == 3'd7)) state_d = (byte_q != '0) ? S_LOAD : S_GAP;
      S_LOAD:  if (div_zero_c) state_d = S_SHIFT;
      S_GAP:   if (div_zero_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs.
  always_comb begin
    div_d  = div_zero_c ? div_q : div_q - CW'(1);
    bit_d  = bit_q;
    byte_d = byte_q;
    sh_d   = sh_q;
    cmd_d  = cmd_q;
    gsel_d = gsel_q;
    rr_d   = rr_q;
    sck_d  = sck_q;
    ss_d   = ss_q;
    di_d   = di_q;
    busy_d = busy_q;
    en_d   = en_q;
    gnt_d  = gnt_q;
    rd_d   = 2'b00;
    done_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          gsel_d = pick_c;
          rr_d   = pick_c;
          cmd_d  = cmd_sel_c;
          sh_d   = cmd_sel_c;
          byte_d = len_clamp_c;
          bit_d  = 3'd0;
          div_d  = DIV_INIT;
          ss_d   = 1'b0;
          di_d   = cmd_sel_c[7];
          gnt_d  = pick_c ? 2'b10 : 2'b01;
          busy_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (div_zero_c) begin
          sck_d = 1'b1;
          div_d = DIV_INIT;
        end
      end
      S_SHIFT: begin
        if (div_zero_c) begin
          div_d = DIV_INIT;
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              if (byte_q != '0) begin
                rd_d   = gnt_q;
                byte_d = byte_q - 9'd1;
                div_d  = LOAD_INIT;
              end else begin
                ss_d   = 1'b1;
                di_d   = 1'b0;
                done_d = gnt_q;
                div_d  = GAP_INIT;
                // Only the enable/disable commands (0x40/0x41) update the mirror.
                if (cmd_q[7:1] == 7'b0100000) en_d = cmd_q[0];
              end
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
              di_d  = sh_q[6];
            end
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Fetch strobe went out on entry; the byte arrives one cycle later.
        if (div_q == LOAD_CAP) begin
          sh_d = data_sel_c;
          di_d = data_sel_c[7];
        end
        if (div_zero_c) begin
          sck_d = 1'b1;
          bit_d = 3'd0;
          div_d = DIV_INIT;
        end
      end
      S_GAP: begin
        if (div_zero_c) begin
          gnt_d  = 2'b00;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      sh_q   <= '0;
      cmd_q  <= '0;
      gsel_q <= 1'b0;
      rr_q   <= 1'b1;
      sck_q  <= 1'b0;
      ss_q   <= 1'b1;
      di_q   <= 1'b0;
      busy_q <= 1'b0;
      en_q   <= 1'b1;
      gnt_q  <= 2'b00;
      rd_q   <= 2'b00;
      done_q <= 2'b00;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      sh_q   <= sh_d;
      cmd_q  <= cmd_d;
      gsel_q <= gsel_d;
      rr_q   <= rr_d;
      sck_q  <= sck_d;
      ss_q   <= ss_d;
      di_q   <= di_d;
      busy_q <= busy_d;
      en_q   <= en_d;
      gnt_q  <= gnt_d;
      rd_q   <= rd_d;
      done_q <= done_d;
    end
  end

  assign data_rd_o      = rd_q;
  assign gnt_o          = gnt_q;
  assign done_o         = done_q;
  assign busy_o         = busy_q;
  assign enable_state_o = en_q;
  assign spi_sck_o      = sck_q;
  assign spi_ss_o       = ss_q;
  assign spi_di_o       = di_q;

endmodule

// File: tb/tb_osd_spi_master.sv
// tb_osd_spi_master: directed + randomized bench for osd_spi_master with an
// SPI slave / overlay-buffer model and a transaction-level reference model.
module tb_osd_spi_master;

  localparam int unsigned D = 2;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req_i   = 2'b00;
  logic [7:0] cmd0_i  = 8'h00, cmd1_i = 8'h00;
  logic [8:0] len0_i  = 9'd0,  len1_i = 9'd0;
  logic [7:0] data0_i = 8'h00, data1_i = 8'h00;
  logic [1:0] data_rd_o, gnt_o, done_o;
  logic       busy_o, enable_state_o, spi_sck_o, spi_ss_o, spi_di_o;

  osd_spi_master #(.CLK_DIV(D)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_i(req_i),
    .cmd0_i(cmd0_i), .cmd1_i(cmd1_i), .len0_i(len0_i), .len1_i(len1_i),
    .data0_i(data0_i), .data1_i(data1_i), .data_rd_o(data_rd_o),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
    .enable_state_o(enable_state_o), .spi_sck_o(spi_sck_o),
    .spi_ss_o(spi_ss_o), .spi_di_o(spi_di_o)
  );

  always #5 clk_sys = ~clk_sys;

  int compared = 0;
  int mismatched = 0;

  // Reference-model state.
  logic       exp_en = 1'b1;
  logic       rr_last = 1'b1;

  // Requester payload sources.
  logic [7:0] pay [2][256];
  int         idx [2] = '{0, 0};
  int         rd_cnt [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};

  // SPI slave / overlay model.
  logic [7:0] sbyte = 8'h00;
  int         sbits = 0;
  logic [7:0] wire_q [$];
  logic [7:0] last_wire [$];
  int         txn_seen = 0;
  logic [7:0] ovbuf [0:8191];
  logic       ov_en = 1'b1;

  // Link timing monitor.
  int         lowc = 0, last_low = 0, highc = 0, min_gap = 1000000;
  bit         seen_end = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  int         gnt_order [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Requesters answer a fetch strobe with the next byte of their payload.
  always @(negedge clk_sys) begin
    if (data_rd_o[0] === 1'b1) begin data0_i = pay[0][idx[0] % 256]; idx[0]++; rd_cnt[0]++; end
    if (data_rd_o[1] === 1'b1) begin data1_i = pay[1][idx[1] % 256]; idx[1]++; rd_cnt[1]++; end
  end

  always @(negedge spi_ss_o) begin
    sbits = 0;
    wire_q.delete();
  end

  always @(posedge spi_sck_o) begin
    if (spi_ss_o === 1'b0) begin
      sbyte = {sbyte[6:0], spi_di_o};
      sbits++;
      if (sbits == 8) begin
        wire_q.push_back(sbyte);
        sbits = 0;
      end
    end
  end

  // Overlay applies a completed frame; an aborted one (reset) is discarded.
  always @(posedge spi_ss_o) begin
    if (reset_n === 1'b1) begin
      last_wire = wire_q;
      txn_seen++;
      if (sbits == 0 && wire_q.size() > 0) begin
        if (wire_q[0][7:5] == 3'b001)
          for (int i = 1; i < wire_q.size(); i++)
            ovbuf[{wire_q[0][4:0], 8'(i - 1)}] = wire_q[i];
        if (wire_q[0][7:1] == 7'b0100000) ov_en = wire_q[0][0];
      end
    end
  end

  always @(negedge clk_sys) begin
    if (reset_n !== 1'b1) begin
      lowc = 0; highc = 0; seen_end = 1'b0; prev_gnt = 2'b00;
    end else begin
      if (spi_ss_o === 1'b0) begin
        if (lowc == 0 && seen_end && highc < min_gap) min_gap = highc;
        lowc++;
        highc = 0;
      end else begin
        if (lowc != 0) begin last_low = lowc; seen_end = 1'b1; end
        lowc = 0;
        highc++;
      end
      if (done_o[0] === 1'b1) done_cnt[0]++;
      if (done_o[1] === 1'b1) done_cnt[1]++;
      if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_order.push_back(int'(gnt_o[1]));
      prev_gnt = gnt_o;
    end
  end

  function automatic int frame_len(input int n);
    return 16 * D + n * (16 * D + 2);
  endfunction

  // One complete single-requester transaction checked against the model.
  task automatic run_txn(input int p, input logic [7:0] cmd, input int len,
                         input bit idx_data, input bit early_drop);
    int n, d_own, d_oth, r0, tseen, errs, limit;
    bit got;
    n = (len > 256) ? 256 : len;
    for (int i = 0; i < 256; i++) pay[p][i] = idx_data ? 8'(i) : 8'($urandom);
    idx[p] = 0;
    if (p == 0) begin cmd0_i = cmd; len0_i = 9'(len); end
    else        begin cmd1_i = cmd; len1_i = 9'(len); end
    d_own = done_cnt[p]; d_oth = done_cnt[1-p]; r0 = rd_cnt[p]; tseen = txn_seen;
    @(negedge clk_sys);
    req_i[p] = 1'b1;
    @(negedge clk_sys);
    chk("start_ss", 32'(spi_ss_o), 32'd0);
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_gnt", 32'(gnt_o), (p == 0) ? 32'd1 : 32'd2);
    got = 1'b0;
    limit = frame_len(n) + 20;
    for (int c = 0; c < limit && !got; c++) begin
      @(negedge clk_sys);
      if (early_drop && (rd_cnt[p] - r0) >= n / 2) req_i[p] = 1'b0;
      if (done_o[p] === 1'b1) got = 1'b1;
    end
    req_i[p] = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    @(negedge clk_sys);
    if (cmd[7:1] == 7'b0100000) exp_en = cmd[0];
    rr_last = 1'(p);
    chk("ss_low_len", 32'(last_low), 32'(frame_len(n)));
    chk("done_own", 32'(done_cnt[p] - d_own), 32'd1);
    chk("done_other", 32'(done_cnt[1-p] - d_oth), 32'd0);
    chk("rd_count", 32'(rd_cnt[p] - r0), 32'(n));
    chk("frames", 32'(txn_seen - tseen), 32'd1);
    chk("wire_bytes", 32'(last_wire.size()), 32'(n + 1));
    errs = 0;
    if (last_wire.size() == n + 1) begin
      if (last_wire[0] !== cmd) errs++;
      for (int i = 0; i < n; i++) if (last_wire[i+1] !== pay[p][i]) errs++;
    end else errs = 1;
    chk("wire_content_errs", 32'(errs), 32'd0);
    chk("enable_state", 32'(enable_state_o), 32'(exp_en));
    chk("overlay_enable", 32'(ov_en), 32'(exp_en));
    for (int c = 0; c < 4 * D + 4 && busy_o === 1'b1; c++) @(negedge clk_sys);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_gnt", 32'(gnt_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    req_i = 2'b00;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    exp_en = 1'b1;
    rr_last = 1'b1;
    @(negedge clk_sys);
  endtask

  initial begin
    int errs, d0, d1, tseen, base, rises, dcount;
    logic prev_sck;
    bit ok;
    logic [7:0] c;

    for (int i = 0; i < 8192; i++) ovbuf[i] = 8'h00;

    // Reset values while reset_n is held low.
    repeat (3) @(negedge clk_sys);
    chk("rst_ss", 32'(spi_ss_o), 32'd1);
    chk("rst_sck", 32'(spi_sck_o), 32'd0);
    chk("rst_di", 32'(spi_di_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rd", 32'(data_rd_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_enable", 32'(enable_state_o), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Command only: disable, enable mirror 1 -> 0.
    run_txn(0, 8'h40, 0, 1'b0, 1'b0);
    chk("cmd_only_frame", 32'(last_wire.size() > 0 ? last_wire[0] : 8'hxx), 32'h40);

    // Line write of 256 bytes to line 3.
    run_txn(1, 8'h23, 256, 1'b1, 1'b0);
    errs = 0;
    for (int i = 0; i < 256; i++) if (ovbuf[13'h300 + 13'(i)] !== 8'(i)) errs++;
    chk("line3_buffer_errs", 32'(errs), 32'd0);

    // Randomized single transactions.
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h40;
        1: c = 8'h41;
        default: c = 8'($urandom);
      endcase
      run_txn(int'($urandom_range(0, 1)), c, int'($urandom_range(0, 12)), 1'b0, 1'b0);
    end

    // Length clamp: 300 requested, 256 fetched, 257 bytes on the wire.
    run_txn(0, 8'h25, 300, 1'b0, 1'b0);

    // Request dropped halfway through still completes.
    run_txn(0, 8'h26, 4, 1'b0, 1'b1);

    // Async reset during bit 3 of payload byte 5.
    for (int i = 0; i < 256; i++) pay[0][i] = 8'($urandom);
    idx[0] = 0;
    cmd0_i = 8'h24; len0_i = 9'd8;
    d0 = done_cnt[0]; tseen = txn_seen; base = rd_cnt[0];
    @(negedge clk_sys);
    req_i[0] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk_sys);
      if (rd_cnt[0] - base >= 6) ok = 1'b1;
    end
    chk("reset_reach_byte5", 32'(ok), 32'd1);
    rises = 0;
    prev_sck = spi_sck_o;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      @(posedge clk_sys);
      #1;
      if (spi_sck_o === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = spi_sck_o;
    end
    chk("reset_reach_bit3", 32'(rises), 32'd4);
    #2;
    reset_n = 1'b0;
    req_i = 2'b00;
    #1;
    chk("async_ss", 32'(spi_ss_o), 32'd1);
    chk("async_sck", 32'(spi_sck_o), 32'd0);
    chk("async_busy", 32'(busy_o), 32'd0);
    chk("async_gnt", 32'(gnt_o), 32'd0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    exp_en = 1'b1;
    rr_last = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("reset_no_done", 32'(done_cnt[0] - d0), 32'd0);
    chk("reset_no_frame", 32'(txn_seen - tseen), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_ss", 32'(spi_ss_o), 32'd1);
    chk("reset_enable", 32'(enable_state_o), 32'd1);

    // Contention after reset: both requests held, strict alternation.
    do_reset();
    for (int i = 0; i < 256; i++) begin pay[0][i] = 8'($urandom); pay[1][i] = 8'($urandom); end
    idx[0] = 0; idx[1] = 0;
    cmd0_i = 8'h21; cmd1_i = 8'h22; len0_i = 9'd2; len1_i = 9'd2;
    gnt_order.delete();
    min_gap = 1000000;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    dcount = 0;
    req_i = 2'b11;
    for (int k = 0; k < 8 * frame_len(2) && dcount < 4; k++) begin
      @(negedge clk_sys);
      if (done_o != 2'b00) dcount++;
    end
    req_i = 2'b00;
    chk("contention_dones", 32'(dcount), 32'd4);
    for (int k = 0; k < 4 * D + 4 && busy_o === 1'b1; k++) @(negedge clk_sys);
    @(negedge clk_sys);
    chk("contention_grants", 32'(gnt_order.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      rr_last = ~rr_last;
      chk("contention_order", (k < gnt_order.size()) ? 32'(gnt_order[k]) : 32'hffff_ffff, 32'(rr_last));
    end
    chk("contention_min_gap_ok", 32'(min_gap >= int'(2 * D + 1)), 32'd1);
    chk("contention_done0", 32'(done_cnt[0] - d0), 32'd2);
    chk("contention_done1", 32'(done_cnt[1] - d1), 32'd2);
    chk("contention_idle", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/osd_spi_master.md
# osd_spi_master

Serialises OSD commands onto the three-wire OSD SPI link (SCK, SS3, DI) from two on-chip requesters, such as a menu engine and a status overlay. It sits between those requesters and the OSD overlay block. It arbitrates round-robin, frames each transaction as one command byte plus up to 256 payload bytes, and mirrors the enable state last sent to the overlay.

## Interface
- `CLK_DIV`, default 4: clk_sys cycles per SCK half-period; legal range 1..255.
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  2  per-requester transaction request; held high until the matching `done_o` pulse.
- `cmd0_i`, `cmd1_i`  in  8  command byte (0x20|line = write line, 0x40/0x41 = disable/enable).
- `len0_i`, `len1_i`  in  9  payload byte count, 0..256; values above 256 are clamped to 256.
- `data0_i`, `data1_i`  in  8  payload byte; must be valid exactly one cycle after the matching `data_rd_o` pulse.
- `data_rd_o`  out  2  one-cycle fetch strobe to the granted requester.
- `gnt_o`  out  2  one-hot grant; held from SETUP through GAP.
- `done_o`  out  2  one-cycle completion pulse to the granted requester.
- `busy_o`  out  1  high in every state except IDLE.
- `enable_state_o`  out  1  mirror of the last enable/disable command sent.
- `spi_sck_o`  out  1  SPI clock; idles low.
- `spi_ss_o`  out  1  SPI chip select (SS3); active low, idles high.
- `spi_di_o`  out  1  SPI data, MSB first.

## Operation
- States: IDLE, SETUP, SHIFT, LOAD, GAP.
- IDLE:
  - The arbiter samples `req_i`. With a single request, that requester is granted.
  - With both requests, the requester not granted last wins. The round-robin pointer resets to favour requester 0.
  - On grant: latch cmd and clamped len; go to SETUP.
- SETUP: `spi_ss_o` goes low, `spi_di_o` = cmd[7], SCK stays low. After CLK_DIV cycles, go to SHIFT.
- SHIFT:
  - Each bit is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - DI changes only on the SCK falling edge; the slave samples on the rising edge.
  - A bit counter (3 bits) and a byte counter (9 bits, remaining bytes) track progress.
  - After the 8th falling edge: if payload bytes remain, go to LOAD; otherwise go to GAP.
- LOAD (payload bytes only):
  - Cycle 0: pulse `data_rd_o[g]`.
  - Cycle 1: capture `dataX_i` into the shift register; drive DI = bit 7.
  - Then hold SCK low for CLK_DIV cycles and return to SHIFT at the rising edge.
- GAP:
  - `spi_ss_o` goes high, SCK low, DI 0. `done_o[g]` pulses in the same cycle.
  - `spi_ss_o` stays high for 2·CLK_DIV cycles. `gnt_o` then clears; go to IDLE.
- Enable mirror: when a transaction whose cmd[7:1] == 7'b0100000 completes, `enable_state_o` takes cmd[0].
- Deasserting a request mid-transaction is ignored. The transaction always completes and `done_o` still pulses.
- Command byte bits are not interpreted except by the enable mirror. Any command is sent as given.

## Timing
- Reset values:
  - `spi_ss_o`=1, `spi_sck_o`=0, `spi_di_o`=0.
  - `gnt_o`=0, `data_rd_o`=0, `done_o`=0, `busy_o`=0.
  - `enable_state_o`=1 (matches the overlay's reset state).
  - Round-robin pointer favours requester 0.
- Reset mid-transaction: all outputs return to reset values asynchronously. No `done_o` pulse. After `reset_n` rises, the block starts in IDLE.
- Latency from `req_i` high in IDLE to `spi_ss_o` low: 1 cycle.
- Transaction length (SS low to SS high): 16·CLK_DIV + len·(16·CLK_DIV + 2) cycles.
- Idle-to-idle gap: SS is high for at least 2·CLK_DIV + 1 cycles between back-to-back transactions.
- `data_rd_o` count equals the clamped len exactly. Payload bytes are requested strictly in order.
- `busy_o` and `gnt_o` rise in the same cycle as SS falls.

## Test plan
- Command only: CLK_DIV=2, req0 with cmd 0x40, len 0.
  - SS low for exactly 32 cycles.
  - DI sampled at 8 SCK rising edges = 0,1,0,0,0,0,0,0.
  - done0 pulses once; `enable_state_o` goes 1→0.
- Line write: req1 with cmd 0x23, len 256, data = fetch index.
  - 256 `data_rd_o[1]` pulses.
  - An overlay-block model's buffer[0x300+i] == i for all i.
  - SS low for 32+256·34 cycles.
- Contention: after reset, both requests asserted continuously.
  - Grant order is 0,1,0,1.
  - Each SS-high gap is at least 2·CLK_DIV+1 cycles.
- Async reset: pull `reset_n` low during bit 3 of payload byte 5.
  - SS=1 and SCK=0 with no clock edge.
  - No done pulse.
  - After release, `busy_o`=0.
- Clamp: len0 = 300 gives exactly 256 fetch pulses and 257 bytes on the wire.
- Early drop: deassert req0 halfway through a transfer. The transfer completes and done0 still pulses.
